// File: rtl/result_reader_pkg.sv
// Shared types and constants for the result RAM read-back path.
package result_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SEND,
    DONE
  } state_t;

  localparam int unsigned BYTES_PER_RES = 3;
  localparam int unsigned DEF_RES_W     = 18;
  localparam int unsigned DEF_ADDR_W    = 8;

  // Byte idx of a zero-padded result word, LSB first.
  function automatic logic [7:0] res_byte(input logic [8*BYTES_PER_RES-1:0] res_wide,
                                          input logic [1:0]                 idx);
    logic [7:0] b;
    b = '0;
    for (int unsigned i = 0; i < BYTES_PER_RES; i++) begin
      if (idx == 2'(i)) b = res_wide[8*i +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/res_serializer.sv
// Holds one captured result and streams it out as bytes under valid/ready.
module res_serializer
  import result_reader_pkg::*;
#(
  parameter int unsigned RES_W = DEF_RES_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [RES_W-1:0] res_in,
  output logic [7:0]       dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             last_byte_accepted
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_RES - 1);

  logic [RES_W-1:0]           res_reg;
  logic [1:0]                 byte_idx;
  logic                       valid;
  logic [8*BYTES_PER_RES-1:0] res_wide;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_reg  <= '0;
      byte_idx <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      res_reg  <= res_in;
      byte_idx <= '0;
      valid    <= 1'b1;
    end else if (valid && dout_ready) begin
      if (byte_idx == LAST_IDX) begin
        byte_idx <= '0;
        valid    <= 1'b0;
      end else begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  always_comb begin
    res_wide              = '0;
    res_wide[RES_W-1:0]   = res_reg;
  end

  assign dout               = valid ? res_byte(res_wide, byte_idx) : '0;
  assign dout_valid         = valid;
  assign last_byte_accepted = valid && dout_ready && (byte_idx == LAST_IDX);

endmodule

// File: rtl/result_reader.sv
// Reads 18-bit results back from the result SRAM and streams each as 3 bytes.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RES_W  = DEF_RES_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_len,
  output logic              cs_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] read_data,
  output logic [7:0]        dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              rd_done
);

  localparam int unsigned     LAT_W   = 3;
  localparam logic [ADDR_W-1:0] ONE_W = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic [LAT_W-1:0]  lat_cnt;
  logic              load;
  logic              last_acc;
  logic              unused_hi;

  assign unused_hi = ^read_data[DATA_W-1:RES_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      lat_cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (rd_start && (rd_len != '0)) begin
            cur_addr  <= rd_base;
            remaining <= rd_len;
          end
        end
        REQ:  lat_cnt <= LAT_W'(RD_LAT);
        WAIT: lat_cnt <= lat_cnt - LAT_W'(1);
        SEND: begin
          if (last_acc && (remaining != ONE_W)) begin
            remaining <= remaining - ONE_W;
            cur_addr  <= cur_addr + ONE_W;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cs_n      = 1'b1;
    rd_done   = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (rd_start) state_nxt = (rd_len != '0) ? REQ : DONE;
      end
      REQ: begin
        cs_n      = 1'b0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_cnt == LAT_W'(1)) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (last_acc) state_nxt = (remaining == ONE_W) ? DONE : REQ;
      end
      DONE: begin
        rd_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign we_n    = 1'b1;
  assign address = cur_addr;

  res_serializer #(
    .RES_W(RES_W)
  ) u_ser (
    .clk               (clk),
    .rst               (rst),
    .load              (load),
    .res_in            (read_data[RES_W-1:0]),
    .dout              (dout),
    .dout_valid        (dout_valid),
    .dout_ready        (dout_ready),
    .last_byte_accepted(last_acc)
  );

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: two instances (RD_LAT 1 and 4) share stimulus, each with its own SRAM model.
module tb_result_reader;

  typedef struct {
    logic [7:0]  base;
    logic [7:0]  len;
    logic        bp;
    int          nbytes;
    logic [95:0] bytes;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_start;
  logic [7:0] rd_base;
  logic [7:0] rd_len;
  logic       dout_ready;
  logic       bp;

  logic        cs_n [2];
  logic        we_n [2];
  logic        dout_valid [2];
  logic        busy [2];
  logic        rd_done [2];
  logic [7:0]  address [2];
  logic [7:0]  dout [2];
  logic [31:0] read_data [2];

  logic [31:0] mem [256];
  logic [8:0]  p0 [4];
  logic [8:0]  p1 [4];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  int         nb [2];
  int         na [2];
  int         ndone [2];
  int         viol [2];
  int         first_v [2];
  int         acc_cyc [2];
  int         done_cyc [2];
  logic       hold [2];
  logic [7:0] hold_d [2];
  logic [7:0] gb [2][16];
  logic [7:0] ga [2][8];
  int         gc [2][8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  result_reader #(.ADDR_W(8), .DATA_W(32), .RES_W(18), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .cs_n(cs_n[0]), .we_n(we_n[0]), .address(address[0]), .read_data(read_data[0]),
    .dout(dout[0]), .dout_valid(dout_valid[0]), .dout_ready(dout_ready),
    .busy(busy[0]), .rd_done(rd_done[0])
  );

  result_reader #(.ADDR_W(8), .DATA_W(32), .RES_W(18), .RD_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .cs_n(cs_n[1]), .we_n(we_n[1]), .address(address[1]), .read_data(read_data[1]),
    .dout(dout[1]), .dout_valid(dout_valid[1]), .dout_ready(dout_ready),
    .busy(busy[1]), .rd_done(rd_done[1])
  );

  // SRAM models: data valid exactly RD_LAT cycles after the cs_n-low cycle, garbage otherwise.
  always @(posedge clk) begin
    p0[0] <= {~cs_n[0], address[0]};
    p1[0] <= {~cs_n[1], address[1]};
    for (int i = 1; i < 4; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign read_data[0] = p0[0][8] ? mem[p0[0][7:0]] : 32'h5A5A_A5A5;
  assign read_data[1] = p1[3][8] ? mem[p1[3][7:0]] : 32'h5A5A_A5A5;

  always @(posedge clk) begin
    #1;
    dout_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!we_n[k]) viol[k]++;
      if (hold[k] && (!dout_valid[k] || dout[k] != hold_d[k])) viol[k]++;
      if (!cs_n[k] && dout_valid[k]) viol[k]++;
      if (!cs_n[k]) begin
        if (na[k] < 8) begin
          ga[k][na[k]] = address[k];
          gc[k][na[k]] = cyc;
        end
        na[k]++;
      end
      if (dout_valid[k]) begin
        if (first_v[k] < 0) first_v[k] = cyc;
        if (dout_ready) begin
          if (nb[k] < 16) gb[k][nb[k]] = dout[k];
          nb[k]++;
          acc_cyc[k] = cyc;
        end
      end
      if (rd_done[k]) begin
        ndone[k]++;
        done_cyc[k] = cyc;
      end
      hold[k]   = dout_valid[k] && !dout_ready;
      hold_d[k] = dout[k];
    end
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      nb[k] = 0; na[k] = 0; ndone[k] = 0; viol[k] = 0;
      first_v[k] = -1; acc_cyc[k] = -1; done_cyc[k] = -1; hold[k] = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_cs_n%0d", tag, k), int'(cs_n[k]), 1);
      chk($sformatf("%s_we_n%0d", tag, k), int'(we_n[k]), 1);
      chk($sformatf("%s_addr%0d", tag, k), int'(address[k]), 0);
      chk($sformatf("%s_dout%0d", tag, k), int'(dout[k]), 0);
      chk($sformatf("%s_valid%0d", tag, k), int'(dout_valid[k]), 0);
      chk($sformatf("%s_busy%0d", tag, k), int'(busy[k]), 0);
      chk($sformatf("%s_done%0d", tag, k), int'(rd_done[k]), 0);
    end
  endtask

  // Issues one rd_start; returns the cycle index of the first cycle after the sampling edge.
  task automatic start_read(input logic [7:0] base, input logic [7:0] len, output int s);
    @(posedge clk);
    #2;
    clear_mon();
    rd_base  = base;
    rd_len   = len;
    rd_start = 1'b1;
    s = cyc + 1;
    @(posedge clk);
    #2;
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && (ndone[0] == 0 || ndone[1] == 0); i++) @(posedge clk);
    chk($sformatf("%s_timeout", tag), int'(ndone[0] != 0 && ndone[1] != 0), 1);
  endtask

  task automatic check_vec(input string tag, input vec_t v, input int s);
    logic [7:0] eb;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_L%0d_ndone", tag, lat(k)), ndone[k], 1);
      chk($sformatf("%s_L%0d_nbytes", tag, lat(k)), nb[k], v.nbytes);
      for (int i = 0; i < v.nbytes && i < nb[k] && i < 16; i++) begin
        eb = v.bytes[8*i +: 8];
        chk($sformatf("%s_L%0d_byte%0d", tag, lat(k), i), int'(gb[k][i]), int'(eb));
      end
      chk($sformatf("%s_L%0d_ncs", tag, lat(k)), na[k], int'(v.len));
      for (int i = 0; i < int'(v.len) && i < na[k] && i < 8; i++) begin
        eb = v.base + 8'(i);
        chk($sformatf("%s_L%0d_addr%0d", tag, lat(k), i), int'(ga[k][i]), int'(eb));
      end
      if (v.len == 8'd0) begin
        chk($sformatf("%s_L%0d_done_cyc", tag, lat(k)), done_cyc[k], s);
      end else begin
        chk($sformatf("%s_L%0d_done_after_last", tag, lat(k)), done_cyc[k], acc_cyc[k] + 1);
        chk($sformatf("%s_L%0d_cs_cyc", tag, lat(k)), gc[k][0], s);
        chk($sformatf("%s_L%0d_first_valid", tag, lat(k)), first_v[k], s + 1 + lat(k));
        if (!v.bp) begin
          for (int i = 1; i < int'(v.len) && i < na[k] && i < 8; i++)
            chk($sformatf("%s_L%0d_period%0d", tag, lat(k), i), gc[k][i] - gc[k][i-1], 4 + lat(k));
        end
      end
      chk($sformatf("%s_L%0d_protocol", tag, lat(k)), viol[k], 0);
    end
  endtask

  vec_t vecs [5];
  int   s;
  vec_t v;

  initial begin
    rst = 1'b1; rd_start = 1'b0; rd_base = '0; rd_len = '0;
    bp = 1'b0; dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin p0[i] = '0; p1[i] = '0; end
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[8'h00] = 32'hFFFC_0001;
    mem[8'h01] = 32'h0000_0002;
    mem[8'h02] = 32'h0003_FFFF;
    mem[8'h03] = 32'h0000_0000;
    mem[8'h10] = 32'h0002_ABCD;
    mem[8'h11] = 32'hFFE1_F00F;
    mem[8'hFE] = 32'h0001_2345;
    mem[8'hFF] = 32'h0000_0FF0;

    vecs[0] = '{base: 8'h10, len: 8'd1, bp: 1'b0, nbytes: 3,  bytes: 96'h02ABCD};
    vecs[1] = '{base: 8'h00, len: 8'd4, bp: 1'b0, nbytes: 12, bytes: 96'h000000_03FFFF_000002_000001};
    vecs[2] = '{base: 8'hFE, len: 8'd3, bp: 1'b0, nbytes: 9,  bytes: 96'h000001_000FF0_012345};
    vecs[3] = '{base: 8'h10, len: 8'd0, bp: 1'b0, nbytes: 0,  bytes: 96'h0};
    vecs[4] = '{base: 8'h00, len: 8'd4, bp: 1'b1, nbytes: 12, bytes: 96'h000000_03FFFF_000002_000001};

    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;

    for (int n = 0; n < 5; n++) begin
      v = vecs[n];
      bp = v.bp;
      start_read(v.base, v.len, s);
      wait_done($sformatf("vec%0d", n));
      bp = 1'b0;
      check_vec($sformatf("vec%0d", n), v, s);
      repeat (2) @(posedge clk);
    end

    // A second rd_start while busy must neither restart nor lengthen the transfer.
    v = '{base: 8'h10, len: 8'd2, bp: 1'b0, nbytes: 6, bytes: 96'h01F00F_02ABCD};
    start_read(v.base, v.len, s);
    repeat (2) @(posedge clk);
    #2;
    rd_base = 8'h40; rd_len = 8'd5; rd_start = 1'b1;
    @(posedge clk);
    #2;
    rd_start = 1'b0;
    wait_done("ignore");
    check_vec("ignore", v, s);
    repeat (4) @(posedge clk);
    chk("ignore_idle_L1", int'(busy[0]), 0);
    chk("ignore_idle_L4", int'(busy[1]), 0);

    // Reset in the middle of word 2 (after its byte 1 is presented and accepted).
    start_read(8'h00, 8'd4, s);
    for (int i = 0; i < 200 && nb[0] < 5; i++) @(negedge clk);
    chk("abort_reached", int'(nb[0] >= 5), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_idle("abort");
    repeat (20) @(posedge clk);
    chk("abort_no_done_L1", ndone[0], 0);
    chk("abort_no_done_L4", ndone[1], 0);
    chk("abort_stay_idle", int'(busy[0] || busy[1]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
